// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;

  // Ceiling log2 for tools without $clog2; returns 0 for values <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Occupancy counters need one extra bit to represent a completely full FIFO.
  function automatic int unsigned count_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  localparam int unsigned DEF_CNT_WIDTH = count_width(DEF_DEPTH);

endpackage

// File: rtl/fifo_mem.sv
// 1W1R register array: synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, programmable almost flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned PTR_WIDTH = clog2(DEPTH),
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 rd_en_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic [PTR_WIDTH:0]   count_o,
  output logic                 wr_error_o,
  output logic                 rd_error_o
);

  localparam int unsigned CNT_W = PTR_WIDTH + 1;

  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] mem_rdata;

  // A write into a full FIFO is allowed when a read frees a slot on the same edge.
  assign wr_acc = wr_en_i & (~full_o | rd_en_i);
  assign rd_acc = rd_en_i & ~empty_o;

  always_comb begin
    count_next = count;
    if (wr_acc && !rd_acc)      count_next = count + CNT_W'(1);
    else if (!wr_acc && rd_acc) count_next = count - CNT_W'(1);
  end

  fifo_mem #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk   (clk_i),
    .we    (wr_acc & ~rst_i),
    .waddr (wr_ptr[PTR_WIDTH-1:0]),
    .wdata (wdata_i),
    .raddr (rd_ptr[PTR_WIDTH-1:0]),
    .rdata (mem_rdata)
  );

  // Flags derive from count_next so they always agree with count_o in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      empty_o        <= 1'b1;
      almost_empty_o <= 1'b1;
      full_o         <= 1'b0;
      almost_full_o  <= (AF_THRESH == 0);
      wr_error_o     <= 1'b0;
      rd_error_o     <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + CNT_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + CNT_W'(1);
      count          <= count_next;
      empty_o        <= (count_next == '0);
      full_o         <= (32'(count_next) == DEPTH);
      almost_full_o  <= (32'(count_next) >= AF_THRESH);
      almost_empty_o <= (32'(count_next) <= AE_THRESH);
      wr_error_o     <= wr_en_i & ~wr_acc;
      rd_error_o     <= rd_en_i & ~rd_acc;
    end
  end

  assign count_o = count;

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata_o = mem_rdata;
`else
  always_ff @(posedge clk_i) begin
    if (rst_i)       rdata_o <= '0;
    else if (rd_acc) rdata_o <= mem_rdata;
  end
`endif

  af_thresh_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    (AF_THRESH >= 1 && AF_THRESH <= DEPTH));
  ae_thresh_legal: assert property (@(posedge clk_i) disable iff (rst_i)
    (AE_THRESH < DEPTH));

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex: vector table plus queue scoreboard.
module tb_sync_fifo_flex;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 16;
  localparam int unsigned AF = 14;
  localparam int unsigned AE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_en = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         rd_en = 1'b0;
  logic [W-1:0] rdata;
  logic         full, empty, afull, aempty;
  logic [4:0]   count;
  logic         wr_err, rd_err;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_rdata = '0;

  always #5 clk = ~clk;

  sync_fifo_flex #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wr_en_i        (wr_en),
    .wdata_i        (wdata),
    .rd_en_i        (rd_en),
    .rdata_o        (rdata),
    .full_o         (full),
    .empty_o        (empty),
    .almost_full_o  (afull),
    .almost_empty_o (aempty),
    .count_o        (count),
    .wr_error_o     (wr_err),
    .rd_error_o     (rd_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_status(input logic w_bad, input logic r_bad);
    int n;
    n = exp_q.size();
    check("count", 32'(count), 32'(n));
    check("full", 32'(full), 32'(n == D));
    check("empty", 32'(empty), 32'(n == 0));
    check("almost_full", 32'(afull), 32'(n >= AF));
    check("almost_empty", 32'(aempty), 32'(n <= AE));
    check("wr_error", 32'(wr_err), 32'(w_bad));
    check("rd_error", 32'(rd_err), 32'(r_bad));
`ifdef SYNC_FIFO_FWFT_EN
    if (n > 0) check("fwft_head", 32'(rdata), 32'(exp_q[0]));
`else
    check("rdata", 32'(rdata), 32'(last_rdata));
`endif
  endtask

  // One clock cycle of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r);
    int n;
    logic wa, ra;
    logic [W-1:0] pv;
    n  = exp_q.size();
    wa = w && (n < D || r);
    ra = r && (n > 0);
    wr_en = w;
    wdata = d;
    rd_en = r;
    #1;
`ifdef SYNC_FIFO_FWFT_EN
    if (ra) check("fwft_pop_data", 32'(rdata), 32'(exp_q[0]));
`endif
    pv = '0;
    if (ra) pv = exp_q.pop_front();
    if (wa) exp_q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    if (ra) last_rdata = pv;
    check_status(w && !wa, r && !ra);
  endtask

  task automatic do_reset(input int cycles, input logic w, input logic r);
    rst   = 1'b1;
    wr_en = w;
    rd_en = r;
    wdata = 8'hEE;
    repeat (cycles) @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    exp_q.delete();
    last_rdata = '0;
    check_status(1'b0, 1'b0);
    check("reset_rdata_or_empty", 32'(empty), 32'd1);
  endtask

  typedef struct {
    logic         w;
    logic [W-1:0] d;
    logic         r;
    logic [4:0]   cnt;
    logic         full;
    logic         empty;
    logic         af;
    logic         ae;
    logic         werr;
    logic         rerr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 8'hA0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'hA1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'hA2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'hA3, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset held for three cycles.
    do_reset(3, 1'b0, 1'b0);
    check("reset_rdata", 32'(rdata), 32'd0);

    // Short vector table from empty.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].w, vecs[i].d, vecs[i].r);
      check("vec_count", 32'(count), 32'(vecs[i].cnt));
      check("vec_full", 32'(full), 32'(vecs[i].full));
      check("vec_empty", 32'(empty), 32'(vecs[i].empty));
      check("vec_af", 32'(afull), 32'(vecs[i].af));
      check("vec_ae", 32'(aempty), 32'(vecs[i].ae));
      check("vec_werr", 32'(wr_err), 32'(vecs[i].werr));
      check("vec_rerr", 32'(rd_err), 32'(vecs[i].rerr));
    end

    // Fill to full, then one rejected write.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0);
      if (i == 12) check("af_before_14", 32'(afull), 32'd0);
      if (i == 13) check("af_at_14", 32'(afull), 32'd1);
    end
    check("full_at_16", 32'(full), 32'd1);
    step(1'b1, 8'hAA, 1'b0);
    check("overflow_pulse", 32'(wr_err), 32'd1);
    check("overflow_count", 32'(count), 32'd16);
    step(1'b0, 8'h00, 1'b0);
    check("overflow_pulse_end", 32'(wr_err), 32'd0);

    // Drain in order, then five underflow reads.
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
      check("drain_data", 32'(rdata), 32'(8'h10 + i));
`endif
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("underflow_pulse", 32'(rd_err), 32'd1);
    end

    // Full plus simultaneous read/write across the pointer wrap.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'b1);
      check("full_rw_count", 32'(count), 32'd16);
    end
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

    // Empty plus simultaneous read/write.
    step(1'b1, 8'h55, 1'b1);
    check("empty_rw_rerr", 32'(rd_err), 32'd1);
    check("empty_rw_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    check("empty_rw_data", 32'(rdata), 32'h55);
`endif

    // Single word visibility and pop.
    step(1'b1, 8'h33, 1'b0);
    step(1'b0, 8'h00, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_no_read", 32'(rdata), 32'h33);
`endif
    step(1'b0, 8'h00, 1'b1);
    check("pop_empty", 32'(empty), 32'd1);

    // Reset mid-fill with a concurrent write request.
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
    check("count_before_reset", 32'(count), 32'd7);
    do_reset(1, 1'b1, 1'b1);
    check("count_after_reset", 32'(count), 32'd0);
    step(1'b1, 8'h99, 1'b0);
    step(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    check("post_reset_data", 32'(rdata), 32'h99);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
- Parametrised single-clock FIFO; next generation of the team's synchronous FIFO.
- Adds occupancy count, programmable almost-full/almost-empty flags and defined simultaneous read/write at both boundaries.
- Keeps one-cycle error pulses on overflow/underflow.
- Sits between a producer and a consumer in the same clock domain as a general buffering primitive.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- PTR_WIDTH, $clog2(DEPTH), address width; derived, do not override.
- AF_THRESH, DEPTH-2, almost_full_o asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2, almost_empty_o asserts when count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- wr_en_i  in  1  write request.
- wdata_i  in  WIDTH  write data.
- rd_en_i  in  1  read request.
- rdata_o  out  WIDTH  read data.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- almost_full_o  out  1  count >= AF_THRESH.
- almost_empty_o  out  1  count <= AE_THRESH.
- count_o  out  PTR_WIDTH+1  current occupancy, 0..DEPTH.
- wr_error_o  out  1  one-cycle pulse, write rejected.
- rd_error_o  out  1  one-cycle pulse, read rejected.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values (at the first rising edge with rst_i=1):
  - pointers = 0, count_o = 0, empty_o = 1, almost_empty_o = 1, full_o = 0.
  - almost_full_o = 0, except 1 if AF_THRESH == 0 (illegal; flag via assertion).
  - wr_error_o = 0, rd_error_o = 0, rdata_o = 0.
  - Memory contents not reset.
- Reset mid-operation discards all contents on that edge; requests in the same cycle are ignored.
- Pointers are PTR_WIDTH+1 bits with a wrap bit. Index = low PTR_WIDTH bits; wrap-around from DEPTH-1 to 0 is natural.
- Acceptance, evaluated on pre-edge state:
  - wr_acc = wr_en_i & (!full_o | rd_en_i).
  - rd_acc = rd_en_i & !empty_o.
  - Full + read + write: both accepted, count unchanged, no error.
  - Empty + read + write: write accepted, read rejected, rd_error_o pulses, count becomes 1.
- Errors are registered and asserted for exactly one cycle after the offending edge:
  - wr_error_o = wr_en_i & !wr_acc.
  - rd_error_o = rd_en_i & !rd_acc.
- Count update: count_next = count + wr_acc - rd_acc.
- All status flags are registered from count_next, so they are always consistent with count_o in the same cycle.
- Standard read mode (macro absent): rdata_o is registered. On a rd_acc edge it loads mem[rd_ptr], so data is visible the cycle after the request (latency 1). Otherwise rdata_o holds.
- Write latency: a word written at edge N is readable by a request sampled at edge N+1; empty_o falls after edge N.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rdata_o = mem[rd_ptr] combinationally and is valid whenever empty_o = 0.
  - rd_en_i acts as a pop acknowledge; the next word is presented after the edge.
  - rdata_o is don't-care while empty.
- Undefined: standard registered read as above.
- Flags, count and errors are identical in both modes.

Decomposition:
- Shared package/header fifo_pkg:
  - Default WIDTH/DEPTH.
  - Function clog2 for tools lacking $clog2.
  - Constant for count width (PTR_WIDTH+1).
- Sub-module fifo_mem: 1W1R register array.
  - Write port: clk, we, waddr, wdata.
  - Read port: asynchronous, raddr -> rdata.
  - The top level adds the output register in standard mode.
- Top level holds pointers, count, flags and errors.

Test Plan:
1. Reset with rst_i=1 for 3 cycles, then deassert. Expect count_o=0, empty_o=1, almost_empty_o=1, full_o=0, rdata_o=0.
2. WIDTH=8, DEPTH=16: write 16 words 0x10..0x1F, then a 17th write 0xAA.
   - almost_full_o rises when count_o=14.
   - full_o=1 at count_o=16.
   - wr_error_o pulses once; count_o stays 16.
3. Read 16 words, then 5 more reads.
   - rdata_o returns 0x10..0x1F in order (1-cycle latency in standard mode).
   - almost_empty_o rises at count_o=2, empty_o at 0.
   - rd_error_o pulses on each of the 5 extra reads.
4. Fill to 16, then assert wr_en_i and rd_en_i together for 20 cycles with data 0x40+i.
   - count_o stays 16, no errors.
   - Read order continues across the pointer wrap.
5. On empty, assert read+write together with 0x55.
   - rd_error_o=1, count_o=1.
   - Next read returns 0x55.
6. With SYNC_FIFO_FWFT_EN defined: write 0x33.
   - rdata_o=0x33 the cycle after, with no read issued.
   - Pop: empty_o=1 after the edge.
   - Assert rst_i mid-fill at count 7: count_o=0 after that edge.
